// File: rtl/serial_add_sub.sv
// Bit-serial 8-bit two's-complement adder/subtractor.
// It processes one bit per clock, LSB first, and publishes the result after eight RUN cycles.
module serial_add_sub (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       op,
  output logic       busy,
  output logic       done,
  output logic [7:0] sum,
  output logic       overflow,
  output logic       carry_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       carry_q, carry_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] sum_q, sum_d;
  logic       overflow_q, overflow_d;
  logic       carry_out_q, carry_out_d;

  logic       fa_a, fa_b, fa_s, fa_c;

  always_comb begin
    fa_a = a_q[cnt_q];
    fa_b = b_q[cnt_q];
    fa_s = fa_a ^ fa_b ^ carry_q;
    fa_c = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    sum_d       = sum_q;
    overflow_d  = overflow_q;
    carry_out_d = carry_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          // Subtraction is a + ~b + 1: invert b here, and the +1 comes from the carry preset.
          b_d     = b ^ {8{op}};
          carry_d = op;
          cnt_d   = 3'd0;
        end
      end
      StRun: begin
        shift_d = {fa_s, shift_q[7:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = StDone;
          sum_d       = {fa_s, shift_q[7:1]};
          carry_out_d = fa_c;
          // carry_q holds the carry into bit 7 on this edge.
          overflow_d  = carry_q ^ fa_c;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      sum_q       <= '0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      sum_q       <= sum_d;
      overflow_q  <= overflow_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign sum       = sum_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub.
// It drives directed corner cases and random operations and compares them against an integer-arithmetic model.
module tb_serial_add_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       op;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       overflow;
  logic       carry_out;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [7:0]  exp_prev_sum;

  serial_add_sub dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The reference uses signed and unsigned integer arithmetic, not a bit-serial evaluation.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mop,
                       output logic [7:0] ms, output logic mov, output logic mco);
    int sa, sb, sr;
    int unsigned ur;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    sr = mop ? (sa - sb) : (sa + sb);
    mov = (sr > 127) || (sr < -128);
    // Raw carry of a + (b ^ op) + op.
    ur = int'(ma) + int'(mop ? (~mb & 8'hFF) : mb) + int'(mop);
    mco = ur[8];
    ms = ur[7:0];
  endtask

  // A full operation with start sampled at edge 0.
  // When inject is set, start is re-driven with new operands at edges 3 and 8.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic top,
                        input bit inject);
    logic [7:0] es;
    logic       eo, ec;
    int         done_cnt;
    model(ta, tb_, top, es, eo, ec);
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; op = top;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("sum_stable", 32'(sum), 32'(exp_prev_sum));
      if (done) done_cnt++;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 1'($urandom);
      start = inject && (i == 2 || i == 7);
      @(negedge clk);
    end
    start = 1'b0;
    if (done) done_cnt++;
    check("busy_done", 32'(busy), 32'd0);
    check("sum", 32'(sum), 32'(es));
    check("overflow", 32'(overflow), 32'(eo));
    check("carry_out", 32'(carry_out), 32'(ec));
    exp_prev_sum = es;
    @(negedge clk);
    if (done) done_cnt++;
    check("busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    if (done) done_cnt++;
    check("idle_after", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("sum_hold", 32'(sum), 32'(es));
  endtask

  task automatic run_abort();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; a = 8'h35; b = 8'h22; op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_co", 32'(carry_out), 32'd0);
    exp_prev_sum = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_sum_kept", 32'(sum), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_prev_sum = 8'h00;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; op = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_co", 32'(carry_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h01, 8'h01, 1'b0, 1'b0);
    run_op(8'h01, 8'h01, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h5A, 8'h33, 1'b1, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    run_abort();
    run_op(8'h12, 8'h34, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
